// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers and state/column types.
// The inverse-coefficient helpers exist only when AES_MIX_INV_EN is defined.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef logic [31:0]  aes_col_t;
    typedef logic [127:0] aes_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (AES_POLY & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

`ifdef AES_MIX_INV_EN
    // Inverse coefficients built from x, x^2 and x^3 multiples.
    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmulb(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gmuld(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gmule(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction
`endif

endpackage

// File: rtl/aes_mix_column.sv
// Combinational MixColumns on a single 32-bit column (byte 0 in [31:24]).
// With AES_MIX_INV_EN defined, inv=1 selects InvMixColumns; otherwise inv is ignored.
module aes_mix_column
    import aes_pkg::*;
(
    input  aes_col_t col,
    input  logic     inv,
    output aes_col_t result
);

    logic [7:0] a0, a1, a2, a3;
    aes_col_t   fwd;

    // Split the column into bytes and form the forward product.
    always_comb begin
        a0  = col[31:24];
        a1  = col[23:16];
        a2  = col[15:8];
        a3  = col[7:0];
        fwd = {gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3,
               a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3,
               a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3),
               gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3)};
    end

`ifdef AES_MIX_INV_EN
    aes_col_t inv_res;

    // Inverse product, selected per column by the latched mode bit.
    always_comb begin
        inv_res = {gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
                   gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
                   gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
                   gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)};
        result  = inv ? inv_res : fwd;
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign result     = fwd;
`endif

endmodule

// File: rtl/aes_mix_columns_engine.sv
// Iterative handshaked MixColumns engine: IDLE -> BUSY (BEATS cycles) -> DONE.
// COLS_PER_CYCLE columns are transformed in place per BUSY cycle.
// Define AES_MIX_INV_EN to build the InvMixColumns path selected by in_inv.
module aes_mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int BEATS  = 4 / COLS_PER_CYCLE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("aes_mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]        state;
    logic [BEAT_W-1:0] beat_cnt;
    aes_state_t        work;
    aes_state_t        work_next;
    aes_state_t        out_q;
    logic              inv_q;
    logic              last_beat;

    aes_col_t col_in  [COLS_PER_CYCLE];
    aes_col_t col_out [COLS_PER_CYCLE];

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_data  = out_q;
    assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));

    // Select the columns owned by the current beat and merge their results back into work.
    always_comb begin
        // NOTE: default every always_comb output up front so no path leaves it unassigned (no latch).
        work_next = work;
        for (int c = 0; c < COLS_PER_CYCLE; c++) begin
            col_in[c] = work[127 - 32 * (int'(beat_cnt) * COLS_PER_CYCLE + c) -: 32];
        end
        for (int c = 0; c < COLS_PER_CYCLE; c++) begin
            work_next[127 - 32 * (int'(beat_cnt) * COLS_PER_CYCLE + c) -: 32] = col_out[c];
        end
    end

    for (genvar c = 0; c < COLS_PER_CYCLE; c++) begin : g_col
        aes_mix_column u_col (
            .col    (col_in[c]),
            .inv    (inv_q),
            .result (col_out[c])
        );
    end

`ifdef AES_MIX_INV_EN
    // Latch the operation mode at accept; it stays fixed until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            inv_q <= in_inv;
        end
    end
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign inv_q         = 1'b0;
`endif

    // FSM, beat counter, working state and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the 128-bit work/out registers are plain flops, so they take the async reset like the FSM;
        // a mid-operation reset therefore leaves nothing of the partial result visible.
        if (!rst_n) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            work     <= '0;
            out_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        beat_cnt <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work <= work_next;
                    if (last_beat) begin
                        beat_cnt <= '0;
                        out_q    <= work_next;
                        state    <= ST_DONE;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_mix_columns_engine.sv
// Self-checking bench for aes_mix_columns_engine.
// Honours AES_MIX_INV_EN the same way as the RTL when choosing expected results.
module tb_aes_mix_columns_engine;

    parameter int COLS = 4;
    localparam int BEATS = 4 / COLS;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_inv = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] exp_q [$];
    bit           in_flight = 1'b0;
    bit           rand_ready_en = 1'b0;

    aes_mix_columns_engine #(.COLS_PER_CYCLE(COLS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Generic GF(2^8) multiply by shift-and-add, reduced by the AES polynomial.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Circulant matrix product per column: r[i] = sum_j coef[(j-i) mod 4] * a[j].
    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   r;
        logic [127:0] res = '0;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 32*k - 8*i -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gf_mul(coef[(j - i + 4) % 4], a[j]);
                res[127 - 32*k - 8*i -: 8] = r;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] expected(input logic [127:0] d, input logic inv);
`ifdef AES_MIX_INV_EN
        return model(d, inv);
`else
        return model(d, 1'b0 & inv);
`endif
    endfunction

    // Scoreboard bookkeeping on handshakes; a reset empties it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            in_flight = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                in_flight = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(expected(in_data, in_inv));
                in_flight = 1'b1;
            end
        end
    end

    // Compare process: output data and ready/valid against the model every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_flight) begin
                check("in_ready_low_busy", {127'd0, in_ready}, 128'd0);
                if (out_valid) begin
                    if (exp_q.size() == 0) check("out_valid_no_txn", {127'd0, out_valid}, 128'd0);
                    else                   check("out_data", out_data, exp_q[0]);
                end
            end else begin
                check("in_ready_idle", {127'd0, in_ready}, 128'd1);
                check("out_valid_idle", {127'd0, out_valid}, 128'd0);
            end
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Offer one state and return 1 time unit after the accepting edge.
    task automatic offer(input logic [127:0] d, input logic inv);
        int tries = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            tries++;
            if (tries > 200) begin
                check("accept_timeout", 128'd1, 128'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait for the output handshake edge, bounded.
    task automatic wait_out_hs();
        int tries = 0;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            tries++;
            if (tries > 200) begin
                check("output_timeout", 128'd1, 128'd0);
                break;
            end
        end
    endtask

    // Send one state, measure edges to out_valid (accept edge counted as 1), check result.
    task automatic run_vector(input string name, input logic [127:0] d, input logic inv,
                              input logic [127:0] lit_exp);
        int lat;
        offer(d, inv);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 128'(lat), 128'(BEATS + 1));
        check({name, "_data"}, out_data, lit_exp);
        wait_out_hs();
    endtask

    initial begin
        logic [127:0] d;
        int           tries;

        // Pin the model itself against hand-known values.
        check("gf_mul_57_83", {120'd0, gf_mul(8'h57, 8'h83)}, {120'd0, 8'hc1});
        check("model_fwd_fips", model(FIPS_IN, 1'b0), FIPS_OUT);
        check("model_inv_fips", model(FIPS_OUT, 1'b1), FIPS_IN);
        check("model_fwd_ones", model(128'h01010101_01010101_01010101_01010101, 1'b0),
              128'h01010101_01010101_01010101_01010101);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FIPS forward vector.
        run_vector("fips_fwd", FIPS_IN, 1'b0, FIPS_OUT);

        // Inverse request: inverse result when built in, forward result otherwise.
`ifdef AES_MIX_INV_EN
        run_vector("fips_inv", FIPS_OUT, 1'b1, FIPS_IN);
`else
        run_vector("fips_inv_off", FIPS_OUT, 1'b1, model(FIPS_OUT, 1'b0));
`endif

        // Additional directed vectors.
        run_vector("zero", 128'd0, 1'b0, 128'd0);
        run_vector("col_bytes", 128'h01000000_00010000_00000100_00000001, 1'b0,
                   128'h02010103_03020101_01030201_01010302);

        // Backpressure: out_ready low, in_valid high with changing data.
        out_ready = 1'b0;
        offer(FIPS_IN, 1'b0);
        tries = 0;
        while (!out_valid && tries < 20) begin
            @(posedge clk);
            #1;
            tries++;
        end
        check("bp_valid_reached", {127'd0, out_valid}, 128'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_inv   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("bp_data_hold", out_data, FIPS_OUT);
            check("bp_no_accept", {127'd0, in_ready}, 128'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_back", {127'd0, in_ready}, 128'd1);
        check("bp_out_valid_drop", {127'd0, out_valid}, 128'd0);

        // Reset during BUSY beat 1 (COLS=1), or the equivalent mid-operation point otherwise.
        out_ready = 1'b0;
        offer(FIPS_IN, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {127'd0, in_ready}, 128'd1);
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_out_data", out_data, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_vector("after_rst", FIPS_OUT, 1'b0, model(FIPS_OUT, 1'b0));

        // Mixed traffic with random gaps, modes and backpressure.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            d = {$urandom, $urandom, $urandom, $urandom};
            offer(d, 1'($urandom_range(0, 1)));
        end
        tries = 0;
        while (in_flight && tries < 200) begin
            @(posedge clk);
            #1;
            tries++;
        end
        check("drain_done", {127'd0, in_flight}, 128'd0);
        rand_ready_en = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
